// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and sizes for the truth-table sweep block
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_VECTORS = 16;
  localparam int IDX_W     = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VECTORS - 1);

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - 4-bit loadable down-counter that sets how long each vector is held
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/truth_table_sweep.sv
// rtl/truth_table_sweep.sv - drives all 16 input vectors to a 4-input circuit and checks its output
module truth_table_sweep
  import sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        x,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        pass
);

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             accept, sample, tmr_load, tmr_dec, tmr_zero, mismatch;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_V),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // abort is only honoured in HOLD, so it beats the final sample but never a fresh start
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = HOLD;
          accept    = 1'b1;
          tmr_load  = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          sample = 1'b1;
          if (idx == LAST_IDX) state_nxt = DONE;
          else                 tmr_load  = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mismatch = (x != expected[idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      table_out <= '0;
      err_count <= '0;
      first_err <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      table_out <= '0;
      err_count <= '0;
      first_err <= '0;
      pass      <= 1'b0;
    end else if (sample) begin
      table_out[idx] <= x;
      if (mismatch) begin
        err_count <= err_count + 5'd1;
        if (err_count == 5'd0) first_err <= idx;
      end
      // pass must include the mismatch being recorded on this same edge
      if (idx == LAST_IDX) pass <= (err_count == 5'd0) && !mismatch;
      else                 idx  <= idx + 1'b1;
    end
  end

  assign {a, b, c, d} = (state == HOLD) ? idx : '0;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweep.sv
// tb/tb_truth_table_sweep.sv - directed self-checking bench for truth_table_sweep
module tb_truth_table_sweep;

  logic clk = 1'b0;
  logic rst;

  // instance with SETTLE=2, circuit under sweep is a 4-input XOR
  logic        start2, abort2, x2, a2, b2, c2, d2, busy2, done2, pass2;
  logic [15:0] expected2, table2;
  logic [4:0]  err2;
  logic [3:0]  first2;

  // instance with SETTLE=0, circuit under sweep is a stuck-at-0 output
  logic        start0, abort0, x0, a0, b0, c0, d0, busy0, done0, pass0;
  logic [15:0] expected0, table0;
  logic [4:0]  err0;
  logic [3:0]  first0;

  int n_vec  = 0;
  int n_miss = 0;
  int obs [0:63];
  int nobs;

  always #5 clk = ~clk;

  assign x2 = a2 ^ b2 ^ c2 ^ d2;
  assign x0 = 1'b0;

  truth_table_sweep #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .expected(expected2), .x(x2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .table_out(table2),
    .err_count(err2), .first_err(first2), .pass(pass2)
  );

  truth_table_sweep #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .expected(expected0), .x(x0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .table_out(table0),
    .err_count(err0), .first_err(first0), .pass(pass0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pulses start on the chosen instance, then counts edges until done while logging {a,b,c,d}
  task automatic run_sweep(input bit sel2, input bit with_abort, output int cyc);
    if (sel2) begin start2 = 1'b1; abort2 = with_abort; end
    else      begin start0 = 1'b1; abort0 = with_abort; end
    tick();
    start2 = 1'b0; abort2 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    cyc  = 0;
    nobs = 0;
    while (!(sel2 ? done2 : done0) && cyc < 200) begin
      if ((sel2 ? busy2 : busy0) && nobs < 64) begin
        obs[nobs] = sel2 ? int'({a2, b2, c2, d2}) : int'({a0, b0, c0, d0});
        nobs++;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic check_vector_order(input string tag, input int hold);
    check({tag, "_nobs"}, nobs, 16 * hold);
    for (int i = 0; i < 16 * hold; i++)
      check($sformatf("%s_vec%0d", tag, i), obs[i], i / hold);
  endtask

  initial begin
    int  cyc;
    bit  saw_done;
    rst = 1'b1;
    start2 = 1'b0; abort2 = 1'b0; expected2 = 16'h6996;
    start0 = 1'b0; abort0 = 1'b0; expected0 = 16'hFFFF;
    tick(); tick();
    check("rst_busy", busy2, 1'b0);
    check("rst_done", done2, 1'b0);
    check("rst_abcd", {a2, b2, c2, d2}, 4'h0);
    check("rst_table", table2, 16'h0000);
    check("rst_err", err2, 5'd0);
    check("rst_first", first2, 4'd0);
    check("rst_pass", pass2, 1'b0);
    rst = 1'b0;
    tick();

    // XOR circuit, matching golden table
    run_sweep(1'b1, 1'b0, cyc);
    check("xor_done_latency", cyc, 48);
    check("xor_done", done2, 1'b1);
    check("xor_busy_in_done", busy2, 1'b1);
    check("xor_abcd_in_done", {a2, b2, c2, d2}, 4'h0);
    check_vector_order("xor", 3);
    tick();
    check("xor_done_one_cycle", done2, 1'b0);
    check("xor_busy_after", busy2, 1'b0);
    check("xor_table", table2, 16'h6996);
    check("xor_err", err2, 5'd0);
    check("xor_first", first2, 4'd0);
    check("xor_pass", pass2, 1'b1);

    // one wrong golden bit at vector 0
    expected2 = 16'h6997;
    run_sweep(1'b1, 1'b0, cyc);
    check("bad0_latency", cyc, 48);
    tick();
    check("bad0_table", table2, 16'h6996);
    check("bad0_err", err2, 5'd1);
    check("bad0_first", first2, 4'd0);
    check("bad0_pass", pass2, 1'b0);

    // stuck-at-0 circuit against all-ones golden, no settle time
    run_sweep(1'b0, 1'b0, cyc);
    check("stuck_latency", cyc, 16);
    check_vector_order("stuck", 1);
    tick();
    check("stuck_table", table0, 16'h0000);
    check("stuck_err", err0, 5'd16);
    check("stuck_first", first0, 4'd0);
    check("stuck_pass", pass0, 1'b0);

    // abort during vector 5
    expected2 = 16'h6996;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 0;
    while ({a2, b2, c2, d2} != 4'd5 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("abort_reach_v5", {a2, b2, c2, d2}, 4'd5);
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    check("abort_busy", busy2, 1'b0);
    check("abort_abcd", {a2, b2, c2, d2}, 4'h0);
    check("abort_table", table2, 16'h0016);
    check("abort_err", err2, 5'd0);
    check("abort_pass", pass2, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done2) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", saw_done, 1'b0);
    check("abort_table_hold", table2, 16'h0016);

    // second start while busy is ignored, then reset mid-sweep
    expected2 = 16'h6994;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("busy_v1", {a2, b2, c2, d2}, 4'd1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("ignored_start_v1", {a2, b2, c2, d2}, 4'd1);
    tick();
    check("ignored_start_v2", {a2, b2, c2, d2}, 4'd2);
    check("pre_rst_table", table2, 16'h0002);
    check("pre_rst_err", err2, 5'd1);
    check("pre_rst_first", first2, 4'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy2, 1'b0);
    check("async_rst_abcd", {a2, b2, c2, d2}, 4'h0);
    check("async_rst_table", table2, 16'h0000);
    check("async_rst_err", err2, 5'd0);
    check("async_rst_first", first2, 4'd0);
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done2 || busy2) saw_done = 1'b1;
      tick();
    end
    check("post_rst_idle", saw_done, 1'b0);

    // fresh sweep after reset, started together with abort (start wins in IDLE)
    expected2 = 16'h6996;
    run_sweep(1'b1, 1'b1, cyc);
    check("fresh_latency", cyc, 48);
    check_vector_order("fresh", 3);
    tick();
    check("fresh_table", table2, 16'h6996);
    check("fresh_err", err2, 5'd0);
    check("fresh_pass", pass2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
